// File: rtl/clk_meas_pkg.sv
// Shared types for the clock period meter: FSM state encoding and default counter width.
package clk_meas_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2,
    ST_DONE = 2'd3
  } meas_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level plus a one-cycle rising-edge pulse.
// The pulse and the synchronized level come out of the same flop, so they always agree.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_sync,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // shift the async input through the synchronizer chain and keep the previous synced level
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_prev;

endmodule

// File: rtl/clk_period_meter.sv
// One-shot period / high-time meter for a slow asynchronous signal, averaged over
// 2**AVG_LOG2 periods and returned on a valid/ready handshake.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start_i
//   ARM     | waiting for the reference rising edge
//   MEAS    | counting total/high cycles until the last averaged rise
//   DONE    | result (or timeout) presented until valid_o & ready_i
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT     = 4000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sig_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             timeout_o
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int EDGE_W = AVG_LOG2 + 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'((1 << AVG_LOG2) - 1);
  localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(TIMEOUT);

  meas_state_t       r_state;
  meas_state_t       w_state_nxt;
  logic              w_sync;
  logic              w_rise;
  logic [CNT_W-1:0]  r_total;
  logic [CNT_W-1:0]  r_high;
  logic [CNT_W-1:0]  r_period;
  logic [CNT_W-1:0]  r_high_avg;
  logic [CNT_W-1:0]  w_total_inc;
  logic [CNT_W-1:0]  w_high_inc;
  logic [EDGE_W-1:0] r_edges;
  logic [IDLE_W-1:0] r_idle;
  logic              r_timeout;
  logic              w_idle_tc;
  logic              w_last_rise;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge_det (
    .i_clk (clk_i),
    .i_rst (rst_i),
    .i_sig (sig_i),
    .o_sync(w_sync),
    .o_rise(w_rise)
  );

  // Idle timer counts down from TIMEOUT; reaching 1 means this edge is the TIMEOUT-th
  // cycle since the last rise (or ARM entry).
  assign w_idle_tc   = (r_idle == IDLE_W'(1));
  assign w_last_rise = w_rise && (r_edges == LAST_EDGE);
  assign w_total_inc = (&r_total) ? r_total : r_total + 1'b1;
  assign w_high_inc  = (w_sync && !(&r_high)) ? r_high + 1'b1 : r_high;

  // state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // next-state decode; a rise always takes priority over the idle timeout
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start_i) w_state_nxt = ST_ARM;
      ST_ARM: begin
        if (w_rise)         w_state_nxt = ST_MEAS;
        else if (w_idle_tc) w_state_nxt = ST_DONE;
      end
      ST_MEAS: begin
        if (w_last_rise)            w_state_nxt = ST_DONE;
        else if (!w_rise && w_idle_tc) w_state_nxt = ST_DONE;
      end
      ST_DONE: if (ready_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // measurement counters and result registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_total    <= '0;
      r_high     <= '0;
      r_edges    <= '0;
      r_idle     <= '0;
      r_period   <= '0;
      r_high_avg <= '0;
      r_timeout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_total <= '0;
            r_high  <= '0;
            r_edges <= '0;
            r_idle  <= IDLE_LOAD;
          end
        end
        ST_ARM: begin
          if (w_rise) begin
            r_idle <= IDLE_LOAD;
          end else begin
            r_idle <= r_idle - 1'b1;
            if (w_idle_tc) begin
              r_period   <= '0;
              r_high_avg <= '0;
              r_timeout  <= 1'b1;
            end
          end
        end
        ST_MEAS: begin
          r_total <= w_total_inc;
          r_high  <= w_high_inc;
          if (w_rise) begin
            r_idle  <= IDLE_LOAD;
            r_edges <= r_edges + 1'b1;
            if (w_last_rise) begin
              r_period   <= w_total_inc >> AVG_LOG2;
              r_high_avg <= w_high_inc >> AVG_LOG2;
              r_timeout  <= 1'b0;
            end
          end else begin
            r_idle <= r_idle - 1'b1;
            if (w_idle_tc) begin
              r_period   <= '0;
              r_high_avg <= '0;
              r_timeout  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (ready_i) r_timeout <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy_o    = (r_state == ST_ARM) || (r_state == ST_MEAS);
  assign valid_o   = (r_state == ST_DONE);
  assign period_o  = r_period;
  assign high_o    = r_high_avg;
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_clk_period_meter.sv
// Bench for clk_period_meter: three instances with different averaging / widths share one
// stimulus; a transaction-level model predicts each result from the pre-generated waveform.
module tb_clk_period_meter;

  localparam int NI   = 3;
  localparam int MAXC = 20000;
  localparam int TO   = 100;
  localparam int SYNC = 2;

  function automatic int inst_avg(input int i);
    case (i)
      0:       return 2;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int inst_w(input int i);
    return (i == 2) ? 4 : 32;
  endfunction

  logic clk     = 1'b0;
  logic rst_i   = 1'b1;
  logic sig_i   = 1'b0;
  logic start_i = 1'b0;
  logic ready_i = 1'b0;

  logic        busy  [NI];
  logic        valid [NI];
  logic        tmo   [NI];
  logic [31:0] per0, hi0, per1, hi1;
  logic [3:0]  per2, hi2;
  logic [31:0] per_v [NI];
  logic [31:0] hi_v  [NI];

  always #5 clk = ~clk;

  clk_period_meter #(.CNT_W(32), .AVG_LOG2(2), .TIMEOUT(TO), .SYNC_STAGES(SYNC)) u0 (
    .clk_i(clk), .rst_i(rst_i), .sig_i(sig_i), .start_i(start_i), .busy_o(busy[0]),
    .valid_o(valid[0]), .ready_i(ready_i), .period_o(per0), .high_o(hi0), .timeout_o(tmo[0]));

  clk_period_meter #(.CNT_W(32), .AVG_LOG2(3), .TIMEOUT(TO), .SYNC_STAGES(SYNC)) u1 (
    .clk_i(clk), .rst_i(rst_i), .sig_i(sig_i), .start_i(start_i), .busy_o(busy[1]),
    .valid_o(valid[1]), .ready_i(ready_i), .period_o(per1), .high_o(hi1), .timeout_o(tmo[1]));

  clk_period_meter #(.CNT_W(4), .AVG_LOG2(0), .TIMEOUT(TO), .SYNC_STAGES(SYNC)) u2 (
    .clk_i(clk), .rst_i(rst_i), .sig_i(sig_i), .start_i(start_i), .busy_o(busy[2]),
    .valid_o(valid[2]), .ready_i(ready_i), .period_o(per2), .high_o(hi2), .timeout_o(tmo[2]));

  assign per_v[0] = per0;
  assign hi_v[0]  = hi0;
  assign per_v[1] = per1;
  assign hi_v[1]  = hi1;
  assign per_v[2] = {28'd0, per2};
  assign hi_v[2]  = {28'd0, hi2};

  // waveform: sig_arr[n] is the value of sig_i sampled at posedge number n
  bit sig_arr [MAXC];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  function automatic bit sv(input int k);
    if (k < 0 || k >= MAXC) return 1'b0;
    return sig_arr[k];
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Given the start edge a, scan the waveform as the synchronizer sees it and work out
  // when the result appears and what it must be.
  task automatic predict(input int a, input int L, input int W, output int done_e,
                         output logic [31:0] per, output logic [31:0] hi, output bit to);
    longint maxv = (longint'(1) << W) - 1;
    longint tot  = 0;
    longint h    = 0;
    int     nr   = -1;
    int     last_clr = a;
    done_e = MAXC + 1000;
    per = '0;
    hi  = '0;
    to  = 1'b0;
    for (int k = a; k < MAXC; k++) begin
      bit sl_k = sv(k - SYNC + 1);
      bit r    = sl_k & ~sv(k - SYNC);
      if (nr >= 0) begin
        tot++;
        if (sl_k) h++;
      end
      if (r) begin
        last_clr = k + 1;
        if (nr < 0) begin
          nr = 0;
        end else begin
          nr++;
          if (nr == (1 << L)) begin
            done_e = k + 1;
            per = 32'(((tot > maxv) ? maxv : tot) >> L);
            hi  = 32'(((h > maxv) ? maxv : h) >> L);
            return;
          end
        end
      end else if (k + 1 - last_clr == TO) begin
        done_e = k + 1;
        to = 1'b1;
        return;
      end
    end
  endtask

  // model state per instance: 0 idle, 1 measuring, 2 result pending
  int          m_st   [NI];
  int          m_done [NI];
  logic [31:0] m_per  [NI];
  logic [31:0] m_hi   [NI];
  bit          m_to   [NI];
  bit          e_busy [NI];
  bit          e_valid[NI];
  bit          e_to   [NI];
  logic [31:0] e_per  [NI];
  logic [31:0] e_hi   [NI];

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_st[i] = 0; m_done[i] = 0; m_per[i] = '0; m_hi[i] = '0; m_to[i] = 1'b0;
      e_busy[i] = 1'b0; e_valid[i] = 1'b0; e_to[i] = 1'b0; e_per[i] = '0; e_hi[i] = '0;
    end
  end

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NI; i++) begin
        m_st[i] = 0;
        e_busy[i] = 1'b0; e_valid[i] = 1'b0; e_to[i] = 1'b0; e_per[i] = '0; e_hi[i] = '0;
      end
    end else begin
      cyc = cyc + 1;
      for (int i = 0; i < NI; i++) begin
        if (m_st[i] == 0) begin
          if (start_i) begin
            predict(cyc, inst_avg(i), inst_w(i), m_done[i], m_per[i], m_hi[i], m_to[i]);
            m_st[i] = 1;
            e_busy[i] = 1'b1;
          end
        end else if (m_st[i] == 1) begin
          if (cyc == m_done[i]) begin
            m_st[i] = 2;
            e_busy[i] = 1'b0;
            e_valid[i] = 1'b1;
            e_per[i] = m_per[i];
            e_hi[i] = m_hi[i];
            e_to[i] = m_to[i];
          end
        end else if (ready_i) begin
          m_st[i] = 0;
          e_valid[i] = 1'b0;
          e_to[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) sig_i = sv(cyc + 1);

  // per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d_busy", i),    busy[i],  e_busy[i]);
      chk($sformatf("u%0d_valid", i),   valid[i], e_valid[i]);
      chk($sformatf("u%0d_timeout", i), tmo[i],   e_to[i]);
      chk($sformatf("u%0d_period", i),  per_v[i], e_per[i]);
      chk($sformatf("u%0d_high", i),    hi_v[i],  e_hi[i]);
    end
  end

  function automatic bit all_idle();
    for (int i = 0; i < NI; i++) if (m_st[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit none_idle();
    for (int i = 0; i < NI; i++) if (m_st[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic fill_const(input int from, input int n, input bit v);
    for (int k = from; k < from + n && k < MAXC; k++) sig_arr[k] = v;
  endtask

  task automatic fill_wave(input int from, input int n, input int p, input int h, input bit jit);
    fill_const(from, n * p + p + 20, 1'b0);
    for (int i = 0; i < n; i++) begin
      int r = from + 3 + p * i + (jit ? int'($urandom_range(0, 1)) : 0);
      for (int j = 0; j < h; j++) if (r + j < MAXC) sig_arr[r + j] = 1'b1;
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_valid(input int i, input int budget);
    int n = 0;
    while (!valid[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d_valid_in_time", i), n < budget, 1);
  endtask

  task automatic wait_all_idle(input int budget, input bit rnd);
    int n = 0;
    while (!all_idle() && n < budget) begin
      @(negedge clk);
      if (rnd) begin
        ready_i = ($urandom_range(0, 2) != 0);
        start_i = none_idle() && ($urandom_range(0, 4) == 0);
      end else begin
        ready_i = 1'b1;
      end
      n++;
    end
    start_i = 1'b0;
    ready_i = 1'b0;
    chk("all_idle_in_time", n < budget, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy[0], 0);
    chk("rst_valid", valid[0], 0);
    chk("rst_period", per_v[0], 0);
    chk("rst_timeout", tmo[0], 0);
    rst_i = 1'b0;
    repeat (4) @(negedge clk);

    // period 10, 50% duty
    fill_wave(cyc + 2, 40, 10, 5, 1'b0);
    pulse_start();
    wait_valid(0, 1000);
    chk("t1_period", per_v[0], 10);
    chk("t1_high", hi_v[0], 5);
    chk("t1_timeout", tmo[0], 0);
    chk("t1_u2_period", per_v[2], 10);
    chk("t1_u2_high", hi_v[2], 5);
    wait_all_idle(2000, 1'b0);

    // sig held low: timeout exactly TO cycles after ARM entry
    fill_const(cyc + 2, 400, 1'b0);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("t2_busy_after_start", busy[0], 1);
    lat = 0;
    while (!valid[0] && lat < 1000) begin
      @(negedge clk);
      lat++;
    end
    chk("t2_timeout_latency", lat, 100);
    chk("t2_timeout", tmo[0], 1);
    chk("t2_period", per_v[0], 0);
    wait_all_idle(2000, 1'b0);
    chk("t2_timeout_cleared", tmo[0], 0);

    // sig held high: no rise either
    fill_const(cyc + 2, 400, 1'b1);
    repeat (10) @(negedge clk);
    pulse_start();
    wait_valid(0, 500);
    chk("t2h_timeout", tmo[0], 1);
    wait_all_idle(2000, 1'b0);
    fill_const(cyc + 2, 400, 1'b0);
    repeat (5) @(negedge clk);

    // period 7 high 3 with one-cycle jitter
    for (int r = 0; r < 3; r++) begin
      fill_wave(cyc + 2, 60, 7, 3, 1'b1);
      pulse_start();
      wait_valid(2, 500);
      chk("t3_avg0_in_6_to_8", (per_v[2] >= 6 && per_v[2] <= 8), 1);
      wait_all_idle(2000, 1'b0);
    end

    // ready held off in DONE, stray start pulses everywhere
    fill_wave(cyc + 2, 60, 12, 4, 1'b0);
    pulse_start();
    n = 0;
    while (!(valid[0] && valid[1] && valid[2]) && n < 2000) begin
      @(negedge clk);
      start_i = (n % 7 == 3);
      n++;
    end
    start_i = 1'b0;
    chk("t4_all_valid_in_time", n < 2000, 1);
    repeat (20) begin
      @(negedge clk);
      start_i = $urandom_range(0, 1) != 0;
    end
    start_i = 1'b0;
    chk("t4_period_held", per_v[0], 12);
    chk("t4_high_held", hi_v[0], 4);
    chk("t4_u1_period_held", per_v[1], 12);
    ready_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    start_i = 1'b0;
    chk("t4_start_on_handshake_ignored", busy[0], 0);
    chk("t4_valid_dropped", valid[0], 0);

    // reset in the middle of a measurement
    fill_wave(cyc + 2, 60, 9, 4, 1'b0);
    pulse_start();
    repeat (30) @(negedge clk);
    chk("t5_busy_before_reset", busy[0], 1);
    @(posedge clk);
    #2 rst_i = 1'b1;
    #1;
    chk("t5_rst_busy", busy[0], 0);
    chk("t5_rst_valid", valid[0], 0);
    chk("t5_rst_period", per_v[0], 0);
    chk("t5_rst_high", hi_v[0], 0);
    @(negedge clk);
    #1 rst_i = 1'b0;
    repeat (6) @(negedge clk);
    pulse_start();
    wait_valid(0, 1000);
    chk("t5_period", per_v[0], 9);
    chk("t5_high", hi_v[0], 4);
    wait_all_idle(2000, 1'b0);

    // period 40 into a 4-bit meter saturates
    fill_wave(cyc + 2, 20, 40, 20, 1'b0);
    pulse_start();
    wait_valid(2, 500);
    chk("t6_u2_period_sat", per_v[2], 15);
    chk("t6_u2_high_sat", hi_v[2], 15);
    wait_valid(0, 1000);
    chk("t6_period", per_v[0], 40);
    chk("t6_high", hi_v[0], 20);
    wait_all_idle(2000, 1'b0);

    // randomized waveforms and handshakes
    for (int it = 0; it < 12; it++) begin
      int p = $urandom_range(3, 30);
      int h = $urandom_range(1, p - 1);
      fill_wave(cyc + 2, 40, p, h, $urandom_range(0, 1) != 0);
      pulse_start();
      wait_all_idle(4000, 1'b1);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
